// File: rtl/pll_reconfig_pkg.sv
// Shared types and constants for the video PLL reconfiguration sequencer.
package pll_reconfig_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_MODE   = 3'd1,
        WR_K      = 3'd2,
        WR_START  = 3'd3,
        WAIT_RCFG = 3'd4,
        WAIT_LOCK = 3'd5
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_MODE  = 6'd0;
    localparam logic [ADDR_W-1:0] ADDR_START = 6'd2;
    localparam logic [ADDR_W-1:0] ADDR_FRACK = 6'd7;

    localparam logic [DATA_W-1:0] MODE_WAITREQ = 32'd0;
    localparam logic [DATA_W-1:0] START_WORD   = 32'd0;

    localparam logic [DATA_W-1:0] K_NATIVE_DEF      = 32'd3639383488;
    localparam logic [DATA_W-1:0] K_UNDER_DEF       = 32'd3262113561;
    localparam int unsigned       STABLE_CYCLES_DEF = 4;
    localparam logic [19:0]       LOCK_TIMEOUT_DEF  = 20'd1000000;

    // A stale synchronised lock from before the retune must not be trusted.
    localparam logic [19:0] LOCK_MIN_CYCLES = 20'd16;

    function automatic logic [DATA_W-1:0] frac_k_word(
        input logic              prof,
        input logic [DATA_W-1:0] k_native,
        input logic [DATA_W-1:0] k_under
    );
        return prof ? k_under : k_native;
    endfunction

endpackage

// File: rtl/pll_reconfig_seq_if.sv
// Avalon-MM-style write-only management port of the PLL reconfiguration block.
interface pll_reconfig_seq_if;
    import pll_reconfig_pkg::*;

    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;

    modport master (
        output write,
        output address,
        output writedata,
        input  waitrequest
    );

    modport slave (
        input  write,
        input  address,
        input  writedata,
        output waitrequest
    );

endinterface

// File: rtl/pll_reconfig_seq_sync_debounce.sv
// Two-flop synchroniser followed by a saturating stability counter.
module sync_debounce #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic stable_o
);
    localparam int unsigned   CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          meta_q;
    logic          sync_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Restart counting whenever the synchronised level is about to change.
    always_comb begin
        cnt_d = cnt_q;
        if (meta_q != sync_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Synchroniser and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            cnt_q  <= cnt_d;
        end
    end

    assign sync_o   = sync_q;
    assign stable_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pll_reconfig_seq.sv
// Retunes the video PLL between native and 60 Hz fractional-K profiles via
// the reconfiguration management port, then waits for relock.
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter logic [31:0] K_NATIVE      = K_NATIVE_DEF,
    parameter logic [31:0] K_UNDER       = K_UNDER_DEF,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter logic [19:0] LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF
) (
    input  logic                      clk_50m,
    input  logic                      reset,
    input  logic                      underclock,
    input  logic                      pll_locked,
    pll_reconfig_seq_if.master        mgmt,
    output logic                      applied,
    output logic                      busy,
    output logic                      done,
    output logic                      lock_err
);

    logic req_sync_s;
    logic req_stable_s;
    logic lock_meta_q;
    logic lock_sync_q;
    logic wr_done_s;

    state_e              state_q,     state_d;
    logic                prof_q,      prof_d;
    logic                target_q,    target_d;
    logic                pending_q,   pending_d;
    logic                write_q,     write_d;
    logic [ADDR_W-1:0]   address_q,   address_d;
    logic [DATA_W-1:0]   writedata_q, writedata_d;
    logic                applied_q,   applied_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                lock_err_q,  lock_err_d;
    logic [19:0]         to_cnt_q,    to_cnt_d;
    logic                rcfg_seen_q, rcfg_seen_d;

    sync_debounce #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_req_sync (
        .clk      (clk_50m),
        .rst_n    (reset),
        .async_i  (underclock),
        .sync_o   (req_sync_s),
        .stable_o (req_stable_s)
    );

    // Plain two-flop synchroniser for the PLL lock indication.
    always_ff @(posedge clk_50m or negedge reset) begin
        if (!reset) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    assign wr_done_s = write_q && !mgmt.waitrequest;

    // Next-state and registered-output logic; the bus outputs of the next
    // write are prepared here so they are driven straight from flops.
    always_comb begin
        state_d     = state_q;
        prof_d      = prof_q;
        target_d    = target_q;
        pending_d   = pending_q;
        write_d     = write_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        applied_d   = applied_q;
        done_d      = 1'b0;
        lock_err_d  = lock_err_q;
        to_cnt_d    = to_cnt_q;
        rcfg_seen_d = rcfg_seen_q;

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    if (target_q != prof_q) begin
                        prof_d      = target_q;
                        state_d     = WR_MODE;
                        write_d     = 1'b1;
                        address_d   = ADDR_MODE;
                        writedata_d = MODE_WAITREQ;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WR_MODE: begin
                if (wr_done_s) begin
                    state_d     = WR_K;
                    address_d   = ADDR_FRACK;
                    writedata_d = frac_k_word(prof_q, K_NATIVE, K_UNDER);
                end else begin
                    state_d = WR_MODE;
                end
            end
            WR_K: begin
                if (wr_done_s) begin
                    state_d     = WR_START;
                    address_d   = ADDR_START;
                    writedata_d = START_WORD;
                end else begin
                    state_d = WR_K;
                end
            end
            WR_START: begin
                if (wr_done_s) begin
                    state_d     = WAIT_RCFG;
                    write_d     = 1'b0;
                    address_d   = '0;
                    writedata_d = '0;
                    rcfg_seen_d = 1'b0;
                end else begin
                    state_d = WR_START;
                end
            end
            WAIT_RCFG: begin
                // Two idle cycles in a row mean the reconfig engine has finished.
                if (!mgmt.waitrequest) begin
                    if (rcfg_seen_q) begin
                        state_d     = WAIT_LOCK;
                        to_cnt_d    = 20'd0;
                        rcfg_seen_d = 1'b0;
                    end else begin
                        rcfg_seen_d = 1'b1;
                    end
                end else begin
                    rcfg_seen_d = 1'b0;
                end
            end
            WAIT_LOCK: begin
                if (lock_sync_q && (to_cnt_q >= LOCK_MIN_CYCLES)) begin
                    applied_d = prof_q;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else if (to_cnt_q >= LOCK_TIMEOUT) begin
                    lock_err_d = 1'b1;
                    applied_d  = prof_q;
                    state_d    = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 20'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                write_d     = 1'b0;
                address_d   = '0;
                writedata_d = '0;
            end
        endcase

        // A newly debounced request overrides the clear issued from IDLE.
        if (req_stable_s && (req_sync_s != target_q)) begin
            target_d  = req_sync_s;
            pending_d = 1'b1;
        end else begin
            target_d = target_d;
        end

        busy_d = (state_d != IDLE);
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk_50m or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            prof_q      <= 1'b0;
            target_q    <= 1'b0;
            pending_q   <= 1'b0;
            write_q     <= 1'b0;
            address_q   <= '0;
            writedata_q <= '0;
            applied_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            lock_err_q  <= 1'b0;
            to_cnt_q    <= 20'd0;
            rcfg_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prof_q      <= prof_d;
            target_q    <= target_d;
            pending_q   <= pending_d;
            write_q     <= write_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            applied_q   <= applied_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            lock_err_q  <= lock_err_d;
            to_cnt_q    <= to_cnt_d;
            rcfg_seen_q <= rcfg_seen_d;
        end
    end

    assign mgmt.write     = write_q;
    assign mgmt.address   = address_q;
    assign mgmt.writedata = writedata_q;
    assign applied        = applied_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign lock_err       = lock_err_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Scoreboard bench for pll_reconfig_seq: stimulus pushes expected writes and
// done outcomes, a negedge monitor pops and compares them.
module tb_pll_reconfig_seq;
    import pll_reconfig_pkg::*;

    localparam logic [31:0] KN  = 32'd3639383488;
    localparam logic [31:0] KU  = 32'd3262113561;
    localparam logic [19:0] LTO = 20'd300;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk_50m    = 1'b0;
    logic reset      = 1'b0;
    logic underclock = 1'b0;
    logic pll_locked = 1'b1;
    logic applied, busy, done, lock_err;

    pll_reconfig_seq_if mgmt();

    pll_reconfig_seq #(
        .K_NATIVE      (KN),
        .K_UNDER       (KU),
        .STABLE_CYCLES (4),
        .LOCK_TIMEOUT  (LTO)
    ) dut (
        .clk_50m    (clk_50m),
        .reset      (reset),
        .underclock (underclock),
        .pll_locked (pll_locked),
        .mgmt       (mgmt.master),
        .applied    (applied),
        .busy       (busy),
        .done       (done),
        .lock_err   (lock_err)
    );

    always #10 clk_50m = ~clk_50m;

    wr_t  exp_wr_q[$];
    logic exp_done_q[$];
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   wr_seen    = 0;
    int   done_seen  = 0;
    int   stall_cfg  = 0;
    int   relock_cfg = 100;

    // bus / PLL model state
    logic       bm_prev_write = 1'b0;
    logic [5:0] bm_prev_addr  = 6'd0;
    int         bm_stall_left = 0;
    int         bm_relock_left = 0;

    // monitor state
    logic        m_prev_write = 1'b0;
    logic        m_prev_wait  = 1'b0;
    logic [5:0]  m_prev_addr  = 6'd0;
    logic [31:0] m_prev_data  = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic prof);
        wr_t w;
        w.addr = ADDR_MODE;  w.data = 32'd0;        exp_wr_q.push_back(w);
        w.addr = ADDR_FRACK; w.data = prof ? KU : KN; exp_wr_q.push_back(w);
        w.addr = ADDR_START; w.data = 32'd0;        exp_wr_q.push_back(w);
    endtask

    task automatic wait_writes(input int target, input int budget, input string name);
        int i;
        i = 0;
        while (wr_seen < target && i < budget) begin
            @(negedge clk_50m);
            i++;
        end
        check(name, (wr_seen >= target), 1'b1);
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int i;
        i = 0;
        while (done_seen < target && i < budget) begin
            @(negedge clk_50m);
            i++;
        end
        check(name, (done_seen >= target), 1'b1);
    endtask

    // Management slave and PLL model, updated just after each active edge.
    initial begin
        mgmt.waitrequest = 1'b0;
        forever begin
            @(posedge clk_50m);
            #1;
            if (bm_prev_write && !mgmt.waitrequest && bm_prev_addr == ADDR_START) begin
                pll_locked     = 1'b0;
                bm_relock_left = relock_cfg;
            end else if (bm_relock_left > 0) begin
                bm_relock_left--;
                if (bm_relock_left == 0) pll_locked = 1'b1;
            end
            if (!mgmt.write) begin
                bm_stall_left    = 0;
                mgmt.waitrequest = 1'b0;
            end else if (!bm_prev_write || !mgmt.waitrequest) begin
                bm_stall_left    = stall_cfg;
                mgmt.waitrequest = (bm_stall_left != 0);
            end else begin
                bm_stall_left--;
                mgmt.waitrequest = (bm_stall_left != 0);
            end
            bm_prev_write = mgmt.write;
            bm_prev_addr  = mgmt.address;
        end
    end

    // Monitor: pops expected writes and done outcomes as the DUT presents them.
    initial begin
        wr_t e;
        logic ed;
        forever begin
            @(negedge clk_50m);
            if (mgmt.write && !mgmt.waitrequest) begin
                wr_seen++;
                if (exp_wr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data %0d, expected none",
                             mgmt.address, mgmt.writedata);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("wr_addr", mgmt.address, e.addr);
                    check("wr_data", mgmt.writedata, e.data);
                end
            end
            if (reset && m_prev_write && m_prev_wait) begin
                check("stall_write_held", mgmt.write, 1'b1);
                check("stall_addr", mgmt.address, m_prev_addr);
                check("stall_data", mgmt.writedata, m_prev_data);
            end
            if (done) begin
                done_seen++;
                if (exp_done_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got applied %0d, expected no done", applied);
                end else begin
                    ed = exp_done_q.pop_front();
                    check("done_applied", applied, ed);
                    check("done_busy_low", busy, 1'b0);
                end
            end
            m_prev_write = mgmt.write;
            m_prev_wait  = mgmt.waitrequest;
            m_prev_addr  = mgmt.address;
            m_prev_data  = mgmt.writedata;
        end
    end

    initial begin
        int t;
        repeat (3) @(negedge clk_50m);
        check("rst_write", mgmt.write, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_applied", applied, 1'b0);
        check("rst_lock_err", lock_err, 1'b0);
        reset = 1'b1;

        // idle, no request
        repeat (40) @(negedge clk_50m);
        check("idle_no_write", wr_seen, 0);
        check("idle_busy", busy, 1'b0);
        check("idle_applied", applied, 1'b0);

        // native -> underclock, no stalls
        push_seq(1'b1);
        exp_done_q.push_back(1'b1);
        #2 underclock = 1'b1;
        wait_done(1, 1000, "seq_under_done");
        @(negedge clk_50m);
        check("seq_under_writes", wr_seen, 3);
        check("seq_under_applied", applied, 1'b1);
        check("seq_under_busy", busy, 1'b0);

        // underclock -> native with 5-cycle stalls on every write
        stall_cfg = 5;
        push_seq(1'b0);
        exp_done_q.push_back(1'b0);
        #2 underclock = 1'b0;
        wait_done(2, 2000, "seq_stall_done");
        @(negedge clk_50m);
        check("seq_stall_writes", wr_seen, 6);
        check("seq_stall_applied", applied, 1'b0);
        stall_cfg = 0;

        // 2-cycle glitch must be ignored
        #2 underclock = 1'b1;
        repeat (2) @(negedge clk_50m);
        #2 underclock = 1'b0;
        repeat (60) @(negedge clk_50m);
        check("glitch_writes", wr_seen, 6);
        check("glitch_busy", busy, 1'b0);

        // request reversal during WAIT_LOCK queues a second sequence
        push_seq(1'b1);
        push_seq(1'b0);
        exp_done_q.push_back(1'b1);
        exp_done_q.push_back(1'b0);
        #2 underclock = 1'b1;
        wait_writes(9, 500, "toggle_first_writes");
        repeat (30) @(negedge clk_50m);
        check("toggle_busy_in_wait_lock", busy, 1'b1);
        #2 underclock = 1'b0;
        wait_done(4, 2000, "toggle_second_done");
        @(negedge clk_50m);
        check("toggle_writes", wr_seen, 12);
        check("toggle_applied", applied, 1'b0);

        // lock never returns: timeout
        relock_cfg = 0;
        push_seq(1'b1);
        #2 underclock = 1'b1;
        wait_writes(15, 500, "timeout_writes");
        t = 0;
        while (!lock_err && t < 2000) begin
            @(negedge clk_50m);
            t++;
        end
        check("timeout_lock_err", lock_err, 1'b1);
        check("timeout_latency_window", (t >= 300 && t <= 310), 1'b1);
        check("timeout_busy", busy, 1'b0);
        check("timeout_applied", applied, 1'b1);
        check("timeout_no_done", done_seen, 4);
        relock_cfg = 100;
        pll_locked = 1'b1;
        repeat (20) @(negedge clk_50m);
        check("lock_err_sticky", lock_err, 1'b1);

        // reset while the K write is stalled
        stall_cfg = 20;
        begin
            wr_t w;
            w.addr = ADDR_MODE; w.data = 32'd0;
            exp_wr_q.push_back(w);
        end
        #2 underclock = 1'b0;
        t = 0;
        while (!(mgmt.write && mgmt.address == ADDR_FRACK) && t < 300) begin
            @(negedge clk_50m);
            t++;
        end
        check("reset_reached_wr_k", (mgmt.write && mgmt.address == ADDR_FRACK), 1'b1);
        #2 reset = 1'b0;
        underclock = 1'b1;
        #1;
        check("reset_write_drop", mgmt.write, 1'b0);
        check("reset_lock_err_clr", lock_err, 1'b0);
        check("reset_applied_clr", applied, 1'b0);
        check("reset_busy_clr", busy, 1'b0);
        check("reset_mode_write_seen", exp_wr_q.size(), 0);
        stall_cfg = 0;
        push_seq(1'b1);
        exp_done_q.push_back(1'b1);
        repeat (3) @(negedge clk_50m);
        #2 reset = 1'b1;

        // after release a full sequence runs; a 1->0->1 flip during it adds none
        wait_writes(19, 500, "post_reset_writes");
        repeat (10) @(negedge clk_50m);
        #2 underclock = 1'b0;
        repeat (12) @(negedge clk_50m);
        #2 underclock = 1'b1;
        wait_done(5, 2000, "post_reset_done");
        repeat (200) @(negedge clk_50m);
        check("flip_no_extra_writes", wr_seen, 19);
        check("flip_busy", busy, 1'b0);
        check("flip_applied", applied, 1'b1);
        check("flip_done_count", done_seen, 5);

        check("sb_writes_drained", exp_wr_q.size(), 0);
        check("sb_done_drained", exp_done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
